// File: rtl/psum_pkg.sv
// Shared parameters and FSM encoding for the partial-sum accumulation path.
package psum_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_KH_W   = 3;
    localparam int unsigned DEF_DIM_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/psum_acc_sched_if.sv
// Psum input stream and finished-pixel output stream of the accumulator.
interface psum_acc_sched_if
    import psum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] psum_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol;
    logic              out_eot;

    modport master (
        output in_valid, psum_in, out_ready,
        input  in_ready, out_valid, out_data, out_eol, out_eot
    );

    modport slave (
        input  in_valid, psum_in, out_ready,
        output in_ready, out_valid, out_data, out_eol, out_eot
    );
endinterface

// File: rtl/psum_tile_cnt.sv
// Nested kernel-row / column / row position counter for one output tile.
module psum_tile_cnt
    import psum_pkg::*;
#(
    parameter int unsigned KH_W  = DEF_KH_W,
    parameter int unsigned DIM_W = DEF_DIM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [KH_W-1:0]  kh,
    input  logic [DIM_W-1:0] out_w,
    input  logic [DIM_W-1:0] out_h,
    output logic             k_first_c,
    output logic             pix_done_c,
    output logic             eol_c,
    output logic             eot_c
);

    logic [KH_W-1:0]  k_cnt;
    logic [DIM_W-1:0] col_cnt;
    logic [DIM_W-1:0] row_cnt;
    logic             row_last_c;

    // Position flags for the psum currently being presented
    assign k_first_c  = (k_cnt == '0);
    assign pix_done_c = (k_cnt == kh - KH_W'(1));
    assign eol_c      = (col_cnt == out_w - DIM_W'(1));
    assign row_last_c = (row_cnt == out_h - DIM_W'(1));
    assign eot_c      = eol_c && row_last_c;

    // Advance k every accepted psum, col on pixel completion, row on col wrap
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k_cnt   <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (step) begin
            if (pix_done_c) begin
                k_cnt <= '0;
                if (eol_c) begin
                    col_cnt <= '0;
                    row_cnt <= row_last_c ? '0 : row_cnt + DIM_W'(1);
                end else begin
                    col_cnt <= col_cnt + DIM_W'(1);
                end
            end else begin
                k_cnt <= k_cnt + KH_W'(1);
            end
        end
    end

endmodule

// File: rtl/psum_acc_sched.sv
// Partial-sum accumulator and tile sequencer: sums cfg_kh psums per pixel
// and streams pixels out with end-of-row / end-of-tile flags.
module psum_acc_sched
    import psum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned KH_W   = DEF_KH_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KH_W-1:0]   cfg_kh,
    input  logic [DIM_W-1:0]  cfg_out_w,
    input  logic [DIM_W-1:0]  cfg_out_h,
    psum_acc_sched_if.slave   bus,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [KH_W-1:0]   kh_q;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  h_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_eol_q;
    logic              out_eot_q;

    logic              in_ready_c;
    logic              accept_c;
    logic              job_start_c;
    logic [DATA_W-1:0] sum_c;
    logic              k_first_c;
    logic              pix_done_c;
    logic              eol_c;
    logic              eot_c;

    // Input is taken only in RUN while the output register is free or draining
    assign in_ready_c  = (state == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept_c    = bus.in_valid && in_ready_c;
    assign job_start_c = (state == ST_IDLE) && start;
    assign sum_c       = k_first_c ? bus.psum_in : acc + bus.psum_in;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eot   = out_eot_q;

    psum_tile_cnt #(
        .KH_W  (KH_W),
        .DIM_W (DIM_W)
    ) u_tile_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (job_start_c),
        .step       (accept_c),
        .kh         (kh_q),
        .out_w      (w_q),
        .out_h      (h_q),
        .k_first_c  (k_first_c),
        .pix_done_c (pix_done_c),
        .eol_c      (eol_c),
        .eot_c      (eot_c)
    );

    // Job FSM, accumulator and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            kh_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eot_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A completing pixel reloads the output even in the handshake cycle
            if (accept_c) begin
                acc <= sum_c;
                if (pix_done_c) begin
                    out_data_q  <= sum_c;
                    out_valid_q <= 1'b1;
                    out_eol_q   <= eol_c;
                    out_eot_q   <= eot_c;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kh_q  <= (cfg_kh == '0) ? KH_W'(1) : cfg_kh;
                        w_q   <= (cfg_out_w == '0) ? DIM_W'(1) : cfg_out_w;
                        h_q   <= (cfg_out_h == '0) ? DIM_W'(1) : cfg_out_h;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_c && pix_done_c && eot_c) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (out_valid_q && bus.out_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_sched.sv
// Testbench for psum_acc_sched: directed jobs with random psums and
// random backpressure, checked against a per-job pixel-sum model.
module tb_psum_acc_sched;
    import psum_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned KW = 3;
    localparam int unsigned MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] cfg_kh;
    logic [MW-1:0] cfg_out_w;
    logic [MW-1:0] cfg_out_h;
    logic          busy;
    logic          done;

    psum_acc_sched_if #(.DATA_W(DW)) bus ();

    psum_acc_sched #(.DATA_W(DW), .KH_W(KW), .DIM_W(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_kh    (cfg_kh),
        .cfg_out_w (cfg_out_w),
        .cfg_out_h (cfg_out_h),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          eol;
        logic          eot;
    } pix_t;

    pix_t          exp_q[$];
    logic [DW-1:0] psq[$];
    int            n_cmp    = 0;
    int            n_err    = 0;
    int            done_cnt = 0;
    int            rdy_mode = 0;
    bit            chk_rate = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pixel p is the mod-2^16 sum of psums p*kh .. p*kh+kh-1
    task automatic model(input int kh, input int w, input int h);
        int kn, wn, hn, idx;
        logic [DW-1:0] s;
        pix_t px;
        kn = (kh == 0) ? 1 : kh;
        wn = (w == 0) ? 1 : w;
        hn = (h == 0) ? 1 : h;
        idx = 0;
        for (int r = 0; r < hn; r++) begin
            for (int c = 0; c < wn; c++) begin
                s = '0;
                for (int k = 0; k < kn; k++) begin
                    s = s + psq[idx];
                    idx++;
                end
                px.data = s;
                px.eol  = (c == wn - 1);
                px.eot  = (c == wn - 1) && (r == hn - 1);
                exp_q.push_back(px);
            end
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard, hold stability, done counting
    logic [DW-1:0] hold_data;
    logic          hold_eol;
    logic          hold_eot;
    bit            hold_v = 1'b0;

    always @(negedge clk) begin
        pix_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'(bus.out_data), 32'(hold_data));
                chk("hold_eol", 32'(bus.out_eol), 32'(hold_eol));
                chk("hold_eot", 32'(bus.out_eot), 32'(hold_eot));
            end
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_eol", 32'(bus.out_eol), 32'(e.eol));
                    chk("out_eot", 32'(bus.out_eot), 32'(e.eot));
                end
            end
            hold_v    = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_eol  = bus.out_eol;
            hold_eot  = bus.out_eot;
        end
    end

    task automatic start_job(input int kh, input int w, input int h);
        done_cnt  = 0;
        cfg_kh    = KW'(kh);
        cfg_out_w = MW'(w);
        cfg_out_h = MW'(h);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_kh    = KW'($urandom);
        cfg_out_w = MW'($urandom);
        cfg_out_h = MW'($urandom);
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic send(input logic [DW-1:0] v);
        int t;
        bus.in_valid = 1'b1;
        bus.psum_in  = v;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        chk("in_accept", 32'(t < 200), 1);
        if (chk_rate) chk("full_rate_wait", 32'(t), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.psum_in  = DW'($urandom);
        if (chk_rate) begin
            chk("lat_valid", 32'(bus.out_valid), 1);
            chk("lat_data", 32'(bus.out_data), 32'(v));
        end
    endtask

    task automatic finish_job(input bit chk_lat);
        int t;
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 32'(t < 2000), 1);
        if (chk_lat) chk("done_latency", 32'(t), 1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("done_count", 32'(done_cnt), 1);
        chk("all_outputs", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_rand(input int kh, input int w, input int h, input int mode);
        int n;
        n = ((kh == 0) ? 1 : kh) * ((w == 0) ? 1 : w) * ((h == 0) ? 1 : h);
        rdy_mode = mode;
        psq.delete();
        repeat (n) psq.push_back(DW'($urandom));
        model(kh, w, h);
        start_job(kh, w, h);
        foreach (psq[i]) send(psq[i]);
        finish_job(1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cfg_kh       = '0;
        cfg_out_w    = '0;
        cfg_out_h    = '0;
        bus.in_valid = 1'b0;
        bus.psum_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_eol", 32'(bus.out_eol), 0);
        chk("rst_out_eot", 32'(bus.out_eot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic: kh=3, 2x1 tile, psums 1..6
        rdy_mode = 0;
        psq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        model(3, 2, 1);
        start_job(3, 2, 1);
        foreach (psq[i]) send(psq[i]);
        finish_job(1'b1);

        // Full rate: kh=1, 4x2 tile, psums 10..17
        psq.delete();
        for (int i = 10; i < 18; i++) psq.push_back(DW'(i));
        model(1, 4, 2);
        start_job(1, 4, 2);
        chk_rate = 1'b1;
        foreach (psq[i]) send(psq[i]);
        chk_rate = 1'b0;
        finish_job(1'b0);

        // Backpressure: kh=2, 1x2 tile, output stalled 5 cycles
        rdy_mode = 2;
        psq = '{16'd1, 16'd2, 16'd7, 16'd8};
        model(2, 1, 2);
        start_job(2, 1, 2);
        send(psq[0]);
        send(psq[1]);
        bus.in_valid = 1'b1;
        bus.psum_in  = psq[2];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_out_data", 32'(bus.out_data), 3);
        end
        rdy_mode = 0;
        send(psq[2]);
        send(psq[3]);
        finish_job(1'b0);

        // Wrap arithmetic
        psq = '{16'h7FFF, 16'h0001, 16'hFFFF};
        model(3, 1, 1);
        start_job(3, 1, 1);
        foreach (psq[i]) send(psq[i]);
        finish_job(1'b0);

        // Zero config values behave as 1
        run_rand(0, 3, 1, 0);
        run_rand(2, 0, 0, 1);

        // Reset after 4 of 6 psums
        rdy_mode = 0;
        psq.delete();
        repeat (6) psq.push_back(DW'($urandom));
        model(3, 2, 1);
        void'(exp_q.pop_back());
        start_job(3, 2, 1);
        for (int i = 0; i < 4; i++) send(psq[i]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_done", 32'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 0);
        chk("midrst_outputs", 32'(exp_q.size()), 0);
        run_rand(3, 2, 1, 1);

        // Second start during RUN is ignored
        rdy_mode = 1;
        psq.delete();
        repeat (4) psq.push_back(DW'($urandom));
        model(2, 2, 1);
        start_job(2, 2, 1);
        send(psq[0]);
        cfg_kh    = 3'd5;
        cfg_out_w = 8'd7;
        cfg_out_h = 8'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 4; i++) send(psq[i]);
        finish_job(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_restart", 32'(busy), 0);

        // Random jobs with random backpressure
        repeat (6) begin
            run_rand($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 3), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
